// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: EX->MEM and MEM->WB field
// layouts, MEM FSM state encoding and data-cache geometry.
package mips_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEST_W = 3;
    localparam int OPC_W  = 4;
    localparam int EX_W   = 38;
    localparam int WB_W   = 37;

    // EX->MEM bit positions
    localparam int EX_ALU_MSB    = 37;
    localparam int EX_ALU_LSB    = 22;
    localparam int EX_MWE_BIT    = 21;
    localparam int EX_WDATA_MSB  = 20;
    localparam int EX_WDATA_LSB  = 5;
    localparam int EX_WBEN_BIT   = 4;
    localparam int EX_DEST_MSB   = 3;
    localparam int EX_DEST_LSB   = 1;
    localparam int EX_WBMUX_BIT  = 0;

    // MEM->WB bit positions
    localparam int WB_WBEN_BIT   = 36;
    localparam int WB_DEST_MSB   = 35;
    localparam int WB_DEST_LSB   = 33;
    localparam int WB_WBMUX_BIT  = 32;
    localparam int WB_ALU_MSB    = 31;
    localparam int WB_ALU_LSB    = 16;
    localparam int WB_RDATA_MSB  = 15;
    localparam int WB_RDATA_LSB  = 0;

    // Data-cache geometry: direct mapped, one word per line
    localparam int CACHE_LINES = 16;
    localparam int CACHE_IDX_W = 4;
    localparam int CACHE_TAG_W = ADDR_W - CACHE_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } mem_state_t;

    // Member order matches the EX->MEM bit positions above (first = MSB)
    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic              mem_write_en;
        logic [DATA_W-1:0] mem_write_data;
        logic              wb_en;
        logic [DEST_W-1:0] wb_dest;
        logic              wb_mux;
    } ex_mem_t;

    // Member order matches the MEM->WB bit positions above (first = MSB)
    typedef struct packed {
        logic              wb_en;
        logic [DEST_W-1:0] wb_dest;
        logic              wb_mux;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_read_data;
    } mem_wb_t;

    function automatic logic [CACHE_IDX_W-1:0] cache_index(input logic [ADDR_W-1:0] addr);
        return addr[CACHE_IDX_W-1:0];
    endfunction

    function automatic logic [CACHE_TAG_W-1:0] cache_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:CACHE_IDX_W];
    endfunction

endpackage

// File: rtl/mem_dcache.sv
// Direct-mapped, one-word-per-line data cache for the MEM stage.
// Combinational lookup, single synchronous write port used for both
// load fills and store write-updates; valid bits clear asynchronously.
module mem_dcache
    import mips_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [CACHE_TAG_W-1:0] r_tag  [CACHE_LINES];
    logic [DATA_W-1:0]      r_data [CACHE_LINES];
    logic [CACHE_LINES-1:0] r_valid;

    logic [CACHE_IDX_W-1:0] w_rd_idx;
    logic [CACHE_IDX_W-1:0] w_wr_idx;
    logic [CACHE_LINES-1:0] w_line_we;

    assign w_rd_idx  = cache_index(i_rd_addr);
    assign w_wr_idx  = cache_index(i_wr_addr);
    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == cache_tag(i_rd_addr));
    assign o_rd_data = r_data[w_rd_idx];

    // One-hot line write enables
    generate
        for (genvar gi = 0; gi < CACHE_LINES; gi++) begin : g_line_we
            assign w_line_we[gi] = i_wr_en && (w_wr_idx == CACHE_IDX_W'(gi));
        end
    endgenerate

    // Tag/data storage: written on fill or write-update, never reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= cache_tag(i_wr_addr);
            r_data[w_wr_idx] <= i_wr_data;
        end
    end

    // Valid bits: cleared by reset, set on any write to the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= r_valid | w_line_we;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: performs loads/stores over a req/ack off-chip memory
// port, stalls the pipeline while a transaction is outstanding and registers
// the result toward WB. Optional data cache enabled by MEM_STAGE_DCACHE_EN;
// without it every load goes off-chip.
module mem_stage
    import mips_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [EX_W-1:0]   pipeline_reg_in,
    input  logic [OPC_W-1:0]  opc_in,
    output logic [WB_W-1:0]   pipeline_reg_out,
    output logic [OPC_W-1:0]  opc_out,
    output logic              memory_stall,
    output logic [DEST_W-1:0] mem_op_dest,
    output logic [DATA_W-1:0] mem_res,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    ex_mem_t           w_ex;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_hit;
    logic [DATA_W-1:0] w_cache_rdata;
    logic              w_stall;
    mem_state_t        r_state;
    mem_state_t        w_state_next;
    mem_wb_t           w_wb_next;
    mem_wb_t           r_wb;
    logic [OPC_W-1:0]  r_opc;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata_cap;

    assign w_ex       = ex_mem_t'(pipeline_reg_in);
    assign w_is_store = w_ex.mem_write_en;
    assign w_is_load  = w_ex.wb_mux && !w_ex.mem_write_en;

`ifdef MEM_STAGE_DCACHE_EN
    logic              w_cache_we;
    logic [DATA_W-1:0] w_cache_wdata;

    // Fill on load completion; write-update only when the store hits
    assign w_cache_we    = (r_state == ST_DONE) && (w_is_load || (w_is_store && w_hit));
    assign w_cache_wdata = w_is_load ? r_rdata_cap : w_ex.mem_write_data;

    mem_dcache u_dcache (
        .clk       (clk),
        .rst       (rst),
        .i_rd_addr (w_ex.alu_result),
        .o_hit     (w_hit),
        .o_rd_data (w_cache_rdata),
        .i_wr_en   (w_cache_we),
        .i_wr_addr (w_ex.alu_result),
        .i_wr_data (w_cache_wdata)
    );
`else
    assign w_hit         = 1'b0;
    assign w_cache_rdata = '0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and combinational stall
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_store) begin
                    w_state_next = ST_WR_WAIT;
                    w_stall      = 1'b1;
                end else if (w_is_load && !w_hit) begin
                    w_state_next = ST_RD_WAIT;
                    w_stall      = 1'b1;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Off-chip request: launched when leaving IDLE, dropped on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (r_state == ST_IDLE && w_state_next != ST_IDLE) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_state_next == ST_WR_WAIT);
            r_mem_addr  <= w_ex.alu_result;
            r_mem_wdata <= w_ex.mem_write_data;
        end else if ((r_state == ST_RD_WAIT || r_state == ST_WR_WAIT) && mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end
    end

    // Capture read data returned with the ack of a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_cap <= '0;
        end else if (r_state == ST_RD_WAIT && mem_ack) begin
            r_rdata_cap <= mem_rdata;
        end
    end

    // Build the WB word: captured data after a miss, cache data on a hit
    always_comb begin
        w_wb_next               = '0;
        w_wb_next.wb_en         = w_ex.wb_en;
        w_wb_next.wb_dest       = w_ex.wb_dest;
        w_wb_next.wb_mux        = w_ex.wb_mux;
        w_wb_next.alu_result    = w_ex.alu_result;
        if (w_is_load) begin
            w_wb_next.mem_read_data = (r_state == ST_DONE) ? r_rdata_cap : w_cache_rdata;
        end
    end

    // MEM->WB register, frozen while the stage stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb  <= '0;
            r_opc <= '0;
        end else if (!w_stall) begin
            r_wb  <= w_wb_next;
            r_opc <= opc_in;
        end
    end

    assign memory_stall     = w_stall;
    assign pipeline_reg_out = r_wb;
    assign opc_out          = r_opc;
    assign mem_op_dest      = w_ex.wb_dest;
    assign mem_res          = w_ex.alu_result;
    assign mem_req          = r_mem_req;
    assign mem_we           = r_mem_we;
    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: pipeline_reg_in  input  38  from EX: [37:22] alu_result/address, [21] mem_write_en, [20:5] mem_write_data, [4] wb_en, [3:1] wb_dest, [0] wb_mux (1 = load).
REQ-004 SHALL have port: opc_in  input  4  opcode from EX.
REQ-005 SHALL have port: pipeline_reg_out  output  37  to WB: [36] wb_en, [35:33] wb_dest, [32] wb_mux, [31:16] alu_result, [15:0] mem_read_data.
REQ-006 SHALL have port: opc_out  output  4  registered opcode to WB.
REQ-007 SHALL have port: memory_stall  output  1  freezes PC, IF, ID, EX registers and this stage's output register.
REQ-008 SHALL have ports: mem_op_dest  output  3  wb_dest of the instruction in MEM (hazard unit); mem_res  output  16  alu_result field of pipeline_reg_in (forwarding).
REQ-009 SHALL have off-chip ports: mem_req out 1; mem_we out 1; mem_addr out 16; mem_wdata out 16; mem_ack in 1 (one-cycle pulse); mem_rdata in 16 (valid with mem_ack).

Function
REQ-010 Load = wb_mux==1 and mem_write_en==0; store = mem_write_en==1; otherwise pass-through; word address = alu_result.
REQ-011 FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
REQ-012 IDLE: store -> WR_WAIT; load miss -> RD_WAIT; load hit or pass-through -> stay IDLE.
REQ-013 RD_WAIT/WR_WAIT: hold mem_req=1, mem_addr, mem_we (1 only in WR_WAIT), mem_wdata stable; on mem_ack capture mem_rdata (RD_WAIT only) and go to DONE; no ack -> stay, unbounded.
REQ-014 DONE: unconditional -> IDLE next cycle; mem_req=0.
REQ-015 memory_stall (combinational) = (IDLE and (store or load miss)) or RD_WAIT or WR_WAIT; 0 in DONE.
REQ-016 mem_req registered: asserted the cycle after leaving IDLE, deasserted the cycle after mem_ack.
REQ-017 pipeline_reg_out and opc_out update on clk only when memory_stall==0; otherwise hold.
REQ-018 mem_read_data field: cache data on hit, captured mem_rdata in DONE, 16'h0000 for non-loads.
REQ-019 Minimum miss/store penalty: ack in first req cycle gives 2 stall cycles; each extra ack-wait cycle adds 1.
REQ-020 mem_ack outside RD_WAIT/WR_WAIT SHALL be ignored.

Reset
REQ-021 On rst: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pipeline_reg_out=0, opc_out=0, all cache valid bits=0, capture register=0.
REQ-022 rst during RD_WAIT/WR_WAIT aborts the transaction immediately; a late mem_ack after reset is ignored.

Configuration
REQ-023 Macro MEM_STAGE_DCACHE_EN: defined -> 16-line direct-mapped data cache, one word/line, index addr[3:0], tag addr[15:4], write-through with write-update on store hit, no allocate on store miss, fill on load miss at DONE.
REQ-024 Undefined -> no cache, every load is a miss (always RD_WAIT), no tag/data storage synthesised; ports unchanged.
REQ-025 Store to address being simultaneously read in a later load SHALL return the stored value (write-update precedes the next lookup).

Structure
REQ-026 Shared package mips_mem_pkg: EX->MEM and MEM->WB field bit positions, FSM state encoding, cache index/tag widths and line count.
REQ-027 Sub-module mem_dcache (tag/valid/data arrays, combinational hit/read, synchronous fill/update, async valid clear) instantiated only under MEM_STAGE_DCACHE_EN.

Verification
REQ-028 Load 0x0040, cache cold, ack after 3 req cycles with rdata 0xBEEF -> stall 4 cycles, mem_addr=0x0040 mem_we=0, WB gets read_data 0xBEEF, wb_mux=1.
REQ-029 (cache on) repeat load 0x0040 -> no stall, no mem_req, read_data 0xBEEF in 1 cycle.
REQ-030 Store 0x1234 to 0x0040, ack on first req cycle -> stall 2 cycles, mem_we=1, mem_wdata=0x1234; then load 0x0040 hits returning 0x1234.
REQ-031 ALU op wb_dest=3 result 0x0007 -> no stall, mem_res=0x0007, mem_op_dest=3, next cycle WB reg alu_result=0x0007, read_data=0.
REQ-032 rst pulse in RD_WAIT then spurious mem_ack -> mem_req=0 same cycle as rst, state IDLE, all outputs 0, load 0x0040 misses again.
REQ-033 Load 0x0050 (index 0) after load 0x0040 cached -> tag conflict miss, refill, subsequent 0x0040 misses.
